// File: rtl/nn_cfg_pkg.sv
// Shared types and helpers for the NN configuration sequencer.
// State encoding, layer count and per-layer size lookup.
package nn_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_B,
        S_NEXT,
        S_DONE
    } state_t;

    localparam int NUM_LAYERS = 3;

    // Returns the per-layer size (neuron count or weight count) for a 1-based layer index.
    function automatic int unsigned layer_size(input logic [1:0] layer,
                                               input int unsigned s1,
                                               input int unsigned s2,
                                               input int unsigned s3);
        case (layer)
            2'd1:    return s1;
            2'd2:    return s2;
            2'd3:    return s3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/nn_cfg_sequencer_counter.sv
// Loadable up-counter with an exact terminal-count compare.
module nn_cfg_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (inc)
            count <= count + 1'b1;
    end

    assign tc = (count == term);

endmodule

// File: rtl/nn_cfg_sequencer.sv
// Streams weight/bias words onto the shared layer/neuron configuration bus.
// Optional macro NN_CFG_LAST_CHECK_EN enables cfg_last framing checks.
module nn_cfg_sequencer
    import nn_cfg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NN_L1      = 30,
    parameter int NW_L1      = 784,
    parameter int NN_L2      = 30,
    parameter int NW_L2      = 30,
    parameter int NN_L3      = 10,
    parameter int NW_L3      = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    input  logic                  cfg_last,
    output logic                  cfg_ready,
    output logic [31:0]           config_layer_num,
    output logic [31:0]           config_neuron_num,
    output logic [31:0]           weightValue,
    output logic                  weightValid,
    output logic [31:0]           biasValue,
    output logic                  biasValid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int M1   = (NN_L1 > NW_L1) ? NN_L1 : NW_L1;
    localparam int M2   = (NN_L2 > NW_L2) ? NN_L2 : NW_L2;
    localparam int M3   = (NN_L3 > NW_L3) ? NN_L3 : NW_L3;
    localparam int MAXV = (M1 > M2) ? ((M1 > M3) ? M1 : M3) : ((M2 > M3) ? M2 : M3);
    localparam int CW   = $clog2(MAXV) + 1;

    state_t          state, state_n;
    logic [1:0]      layer, layer_n;
    logic [CW-1:0]   w_count, n_count, nw_term, nn_term;
    logic            w_tc, n_tc;
    logic            w_load, w_inc, n_load, n_inc, start_acc;
    logic            xfer, w_xfer, b_xfer;
    logic            early_last, last_miss;

    assign nw_term = CW'(layer_size(layer, NW_L1, NW_L2, NW_L3) - 1);
    assign nn_term = CW'(layer_size(layer, NN_L1, NN_L2, NN_L3) - 1);

    nn_cfg_counter #(.W(CW)) u_wcnt (
        .clk(clk), .rst(rst), .load(w_load), .load_val('0), .inc(w_inc),
        .term(nw_term), .count(w_count), .tc(w_tc)
    );

    nn_cfg_counter #(.W(CW)) u_ncnt (
        .clk(clk), .rst(rst), .load(n_load), .load_val('0), .inc(n_inc),
        .term(nn_term), .count(n_count), .tc(n_tc)
    );

    assign xfer   = cfg_valid && cfg_ready;
    assign w_xfer = xfer && (state == S_LOAD_W);
    assign b_xfer = xfer && (state == S_LOAD_B);

`ifdef NN_CFG_LAST_CHECK_EN
    logic is_final;
    assign is_final   = (state == S_LOAD_B) && (layer == 2'd3) && n_tc;
    assign early_last = xfer && cfg_last && !is_final;
    assign last_miss  = xfer && is_final && !cfg_last;
`else
    // Framing is not checked in this build; cfg_last is tied off here so it stays referenced.
    assign early_last = 1'b0;
    assign last_miss  = cfg_last & 1'b0;
`endif

    always_comb begin
        state_n   = state;
        layer_n   = layer;
        w_load    = 1'b0;
        w_inc     = 1'b0;
        n_load    = 1'b0;
        n_inc     = 1'b0;
        start_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_LOAD_W;
                    layer_n   = 2'd1;
                    w_load    = 1'b1;
                    n_load    = 1'b1;
                    start_acc = 1'b1;
                end
            end
            S_LOAD_W: begin
                if (early_last) begin
                    state_n = S_IDLE;
                end else if (xfer) begin
                    w_inc = 1'b1;
                    if (w_tc)
                        state_n = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (early_last)
                    state_n = S_IDLE;
                else if (xfer)
                    state_n = S_NEXT;
            end
            S_NEXT: begin
                w_load = 1'b1;
                if (!n_tc) begin
                    n_inc   = 1'b1;
                    state_n = S_LOAD_W;
                end else if (layer != 2'(NUM_LAYERS)) begin
                    layer_n = layer + 2'd1;
                    n_load  = 1'b1;
                    state_n = S_LOAD_W;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            layer             <= '0;
            cfg_ready         <= 1'b0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            weightValue       <= '0;
            weightValid       <= 1'b0;
            biasValue         <= '0;
            biasValid         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
        end else begin
            state       <= state_n;
            layer       <= layer_n;
            cfg_ready   <= (state_n == S_LOAD_W) || (state_n == S_LOAD_B);
            busy        <= (state_n == S_LOAD_W) || (state_n == S_LOAD_B) || (state_n == S_NEXT);
            done        <= (state_n == S_DONE);
            weightValid <= w_xfer && !early_last;
            biasValid   <= b_xfer && !early_last;
            if (w_xfer && !early_last)
                weightValue <= 32'(cfg_data);
            if (b_xfer && !early_last)
                biasValue <= 32'(cfg_data);
            // Bus address only moves with a neuron's first weight so decoders see it stable through the bias.
            if (w_xfer && !early_last && (w_count == '0)) begin
                config_layer_num  <= 32'(layer);
                config_neuron_num <= 32'(n_count);
            end else if ((state_n == S_DONE) || early_last) begin
                config_layer_num  <= '0;
                config_neuron_num <= '0;
            end
            if (start_acc)
                err <= 1'b0;
            else if (early_last || last_miss)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nn_cfg_sequencer.sv
// Scoreboard bench for nn_cfg_sequencer with a reduced 2/2/1 x 3/2/2 network.
module tb_nn_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, cfg_valid, cfg_last;
    logic [31:0] cfg_data;
    logic        cfg_ready, weightValid, biasValid, busy, done, err;
    logic [31:0] config_layer_num, config_neuron_num, weightValue, biasValue;

    typedef struct {
        bit          is_bias;
        logic [31:0] val;
        int          lay;
        int          neu;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   wv_cnt, bv_cnt, done_cnt, done_cyc, bias_cyc;
    int   nn_t[4] = '{0, 2, 2, 1};
    int   nw_t[4] = '{0, 3, 2, 2};

    nn_cfg_sequencer #(
        .DATA_WIDTH(32), .NN_L1(2), .NW_L1(3), .NN_L2(2), .NW_L2(2), .NN_L3(1), .NW_L3(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_last(cfg_last), .cfg_ready(cfg_ready), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .weightValue(weightValue), .weightValid(weightValid),
        .biasValue(biasValue), .biasValid(biasValid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t exp_word(input int k);
        exp_t e;
        int   c = 0;
        e.is_bias = 0; e.val = 0; e.lay = 0; e.neu = 0;
        for (int l = 1; l <= 3; l++)
            for (int n = 0; n < nn_t[l]; n++)
                for (int w = 0; w <= nw_t[l]; w++) begin
                    c++;
                    if (c == k) begin
                        e.is_bias = (w == nw_t[l]);
                        e.val     = k;
                        e.lay     = l;
                        e.neu     = n;
                    end
                end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] v;
        if (weightValid || biasValid) begin
            checks++;
            v = biasValid ? biasValue : weightValue;
            if (weightValid && biasValid) begin
                errors++;
                $display("FAIL strobe_overlap: weightValid=1 biasValid=1, required only one");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: bias=%0b value=%0d with empty scoreboard", biasValid, v);
            end else begin
                e = sb.pop_front();
                if (biasValid !== e.is_bias || v !== e.val ||
                    config_layer_num !== e.lay || config_neuron_num !== e.neu) begin
                    errors++;
                    $display("FAIL strobe: got bias=%0b val=%0d L=%0d N=%0d, required bias=%0b val=%0d L=%0d N=%0d",
                             biasValid, v, config_layer_num, config_neuron_num,
                             e.is_bias, e.val, e.lay, e.neu);
                end
                if (biasValid) begin bv_cnt++; bias_cyc = cyc; end
                else wv_cnt++;
            end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    task automatic clr_stats;
        wv_cnt = 0; bv_cnt = 0; done_cnt = 0; done_cyc = -1; bias_cyc = -1;
    endtask

    task automatic do_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit rnd, input int start_at,
                              input int last_at, input int drop_at);
        int k = 1;
        int guard = 0;
        while (k <= n && guard < 2000) begin
            cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_data  = k;
            cfg_last  = (k == last_at);
            start     = (k == start_at);
            if (cfg_valid && cfg_ready) begin
                if (k != drop_at) sb.push_back(exp_word(k));
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        cfg_valid = 1'b0; cfg_last = 1'b0; start = 1'b0;
        checks++;
        if (k <= n) begin
            errors++;
            $display("FAIL send_timeout: accepted %0d words, required %0d", k - 1, n);
        end
    endtask

    task automatic check_load(input string tag, input logic exp_err);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL %s_pending: %0d outstanding, required 0", tag, sb.size());
        end
        checks++;
        if (wv_cnt != 12 || bv_cnt != 5) begin
            errors++; $display("FAIL %s_counts: weights=%0d biases=%0d, required 12 and 5", tag, wv_cnt, bv_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != bias_cyc + 1) begin
            errors++; $display("FAIL %s_done: pulses=%0d at cyc %0d (last bias %0d), required 1 at bias+1",
                               tag, done_cnt, done_cyc, bias_cyc);
        end
        checks++;
        if (err !== exp_err || busy !== 1'b0 || cfg_ready !== 1'b0 ||
            config_layer_num !== 0 || config_neuron_num !== 0) begin
            errors++; $display("FAIL %s_end: err=%0b busy=%0b ready=%0b L=%0d N=%0d, required err=%0b and rest 0",
                               tag, err, busy, cfg_ready, config_layer_num, config_neuron_num, exp_err);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (cfg_ready !== 0 || config_layer_num !== 0 || config_neuron_num !== 0 ||
            weightValue !== 0 || weightValid !== 0 || biasValue !== 0 || biasValid !== 0 ||
            busy !== 0 || done !== 0 || err !== 0) begin
            errors++;
            $display("FAIL %s: ready=%0b L=%0d N=%0d wv=%0d/%0b bv=%0d/%0b busy=%0b done=%0b err=%0b, required all 0",
                     tag, cfg_ready, config_layer_num, config_neuron_num, weightValue, weightValid,
                     biasValue, biasValid, busy, done, err);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        clr_stats();
        do_start();
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++; $display("FAIL start_accept: busy=%0b ready=%0b, required 1 1", busy, cfg_ready);
        end
        send_words(17, 1'b0, 0, 17, 0);
        check_load("basic", 1'b0);
    endtask

    task automatic test_random_valid;
        clr_stats();
        do_start();
`ifdef NN_CFG_LAST_CHECK_EN
        send_words(17, 1'b1, 0, 17, 0);
`else
        send_words(17, 1'b1, 0, 3, 0);
`endif
        check_load("random_valid", 1'b0);
    endtask

    task automatic test_start_while_busy;
        clr_stats();
        do_start();
        send_words(17, 1'b0, 6, 17, 0);
        check_load("start_busy", 1'b0);
    endtask

    task automatic test_rst_mid;
        clr_stats();
        do_start();
        send_words(8, 1'b0, 0, 0, 0);
        rst = 1'b1; cfg_valid = 1'b1; cfg_data = 32'd9;
        @(posedge clk); #1;
        check_idle_outputs("rst_mid");
        rst = 1'b0; cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || done_cnt != 0 || wv_cnt != 6 || bv_cnt != 2) begin
            errors++; $display("FAIL rst_mid_partial: pending=%0d done=%0d w=%0d b=%0d, required 0 0 6 2",
                               sb.size(), done_cnt, wv_cnt, bv_cnt);
        end
        clr_stats();
        do_start();
        send_words(17, 1'b0, 0, 17, 0);
        check_load("after_rst", 1'b0);
    endtask

`ifdef NN_CFG_LAST_CHECK_EN
    task automatic test_last_early;
        clr_stats();
        do_start();
        send_words(10, 1'b0, 0, 10, 10);
        cfg_valid = 1'b1; cfg_data = 32'd11;
        repeat (5) @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done_cnt != 0 || wv_cnt != 7 || bv_cnt != 2 || sb.size() != 0) begin
            errors++; $display("FAIL last_early: err=%0b busy=%0b done=%0d w=%0d b=%0d, required 1 0 0 7 2",
                               err, busy, done_cnt, wv_cnt, bv_cnt);
        end
    endtask

    task automatic test_last_missing;
        clr_stats();
        do_start();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear_on_start: err=%0b, required 0", err);
        end
        send_words(17, 1'b0, 0, 0, 0);
        check_load("last_missing", 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random_valid();
        test_start_while_busy();
        test_rst_mid();
`ifdef NN_CFG_LAST_CHECK_EN
        test_last_early();
        test_last_missing();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_cfg_sequencer.md
Name: nn_cfg_sequencer

Overview:
Configuration controller for the 3-layer fully connected network. Accepts a flat stream of 32-bit weight/bias words and walks it through layer, neuron and weight counters. Drives the shared configuration bus (layer number, neuron number, weight/bias value and valid) that every layer and neuron decodes. Replaces per-word software writes of layer/neuron registers with one streamed load, started by a single pulse.

Parameters:
DATA_WIDTH, 32, width of config words and of the weight/bias values
NN_L1, 30, neurons in layer 1
NW_L1, 784, weights per neuron in layer 1
NN_L2, 30, neurons in layer 2
NW_L2, 30, weights per neuron in layer 2
NN_L3, 10, neurons in layer 3
NW_L3, 30, weights per neuron in layer 3

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a full load; ignored unless IDLE
cfg_data  in  DATA_WIDTH  stream word
cfg_valid  in  1  stream valid
cfg_last  in  1  stream last marker (used only with the optional feature)
cfg_ready  out  1  stream ready
config_layer_num  out  32  target layer, 1..3
config_neuron_num  out  32  target neuron within layer, 0-based
weightValue  out  32  weight word, zero-extended from DATA_WIDTH
weightValid  out  1  one-cycle write strobe for weightValue
biasValue  out  32  bias word
biasValid  out  1  one-cycle write strobe for biasValue
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse when the last bias has been issued
err  out  1  sticky; cleared by rst or by the next accepted start

Behaviour:
- Reset values: every output 0; state IDLE; all counters 0.
- Stream order: layer 1 through 3; within a layer, neuron 0 through NN-1; per neuron, NW weights, then 1 bias.
- Handshake: a word transfers when cfg_valid && cfg_ready.
- cfg_ready is a registered output. It is 1 in LOAD_W and LOAD_B, and 0 in every other state.
- Output latency: 1 cycle. On the clock after a transfer, weightValue/weightValid (or biasValue/biasValid) are presented.
- config_layer_num and config_neuron_num change only on the cycle the first weight of a neuron is presented. They are held stable through that neuron's bias strobe.
- Valids are single-cycle pulses and never assert together.
- States:
  - IDLE: start -> LOAD_W; layer=1, neuron=0, wcnt=0; busy=1; err=0.
  - LOAD_W: on each transfer, wcnt++. When wcnt reaches NW(layer)-1 on a transfer -> LOAD_B.
  - LOAD_B: on transfer -> NEXT.
  - NEXT: single bubble cycle, cfg_ready=0.
    - If neuron<NN(layer)-1: neuron++, wcnt=0 -> LOAD_W.
    - Else if layer<3: layer++, neuron=0 -> LOAD_W.
    - Else -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE. Config numbers return to 0.
- Counters are sized by $clog2 of the largest NN/NW plus 1. No wrap-around is possible because the terminal compares are exact.
- cfg_valid low stalls the sequence indefinitely; no timeout.
- start while busy is ignored and does not set err.
- rst mid-load: outputs drop to reset values in the same edge, and partially loaded neurons keep their words. Software reloads from start.
- Total words accepted equals sum over layers of NN*(NW+1). For the defaults that is 30*785 + 30*31 + 10*31 = 24790.

Optional Feature:
Macro NN_CFG_LAST_CHECK_EN.
- Defined:
  - cfg_last must be 1 exactly on the final bias word.
  - cfg_last=1 on any earlier word sets err, drops to IDLE without done, and leaves busy=0.
  - cfg_last=0 on the final word sets err but still completes with done.
- Not defined: cfg_last is ignored and err stays 0.

Decomposition:
- Shared package (nn_cfg_pkg) holds:
  - state encoding constants S_IDLE, S_LOAD_W, S_LOAD_B, S_NEXT, S_DONE
  - NUM_LAYERS=3
  - the function returning NN/NW for a layer index
- One natural sub-module, nn_cfg_counter: loadable up-counter with terminal-count flag, instantiated for wcnt and neuron.
- The layer index stays in the FSM.

Test Plan:
- Small parameters NN=2/2/1, NW=3/2/2, cfg_valid held 1, words 1..17 -> 17 accepts; 12 weightValid and 5 biasValid.
  - Bias values 4, 8, 11, 14, 17.
  - (layer, neuron) sequence: (1,0), (1,1), (2,0), (2,1), (3,0).
  - done pulses exactly once, 1 cycle after the bias of 17.
- Same load with cfg_valid toggling on a random 50% pattern -> identical strobe/value sequence; only timing stretches.
- start asserted again at word 6 -> ignored; sequence unchanged; err=0.
- rst asserted at word 9 -> next cycle all outputs 0, state IDLE. A following start plus 17 words completes normally.
- With NN_CFG_LAST_CHECK_EN and cfg_last on word 10 -> err=1, busy=0, no done, no strobes after word 10.
- With NN_CFG_LAST_CHECK_EN and cfg_last held 0 on word 17 -> done=1 and err=1.
